mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Sequential signed 32-bit multiply/divide unit for the multicycle datapath.
- Directly downstream of the A/B operand registers: consumes their outputs and produces HI/LO results for the MFHI/MFLO path.
- The control unit issues a one-cycle start and stalls in a wait state until done.
- Multiply uses radix-2 Booth; divide uses restoring division on magnitudes with a sign fix-up.

Parameters:
- WIDTH, 32, operand and result width of each of hi/lo.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  1  0 = MULT, 1 = DIV; sampled with start.
- a_in  in  WIDTH  multiplicand/dividend (A register output); sampled with start.
- b_in  in  WIDTH  multiplier/divisor (B register output); sampled with start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when a result is valid.
- div_zero  out  1  set on completion of a DIV with b_in == 0.
- hi  out  WIDTH  MULT: product[2W-1:W]; DIV: remainder.
- lo  out  WIDTH  MULT: product[W-1:0]; DIV: quotient.

Behaviour:
- Reset (reset low, async): state=IDLE; hi=lo=0; busy=done=div_zero=0; all internal registers cleared.
- States: IDLE, MULT, DIV, FIX, DONE.
- IDLE: start=1 latches op/a_in/b_in, clears div_zero and the iteration counter.
  - op=0 -> MULT.
  - op=1, b_in!=0 -> DIV.
  - op=1, b_in==0 -> DONE.
- MULT:
  - Registers: acc is WIDTH+1 bits, sign-extended, to absorb -2^(W-1) subtraction; q=a_in; q_1=0; m=sext(b_in).
  - Per cycle, look at {q[0],q_1}: 01 -> acc+=m; 10 -> acc-=m; 00/11 -> no add.
  - Then arithmetic right shift of {acc,q,q_1} by 1.
  - After WIDTH iterations -> DONE; hi=acc[W-1:0], lo=q.
- DIV:
  - Operate on unsigned magnitudes |a|, |b| (WIDTH bits; |-2^(W-1)| = 2^(W-1) unsigned).
  - Remainder register is WIDTH+1 bits.
  - Per cycle: shift {rem,quo} left by 1; trial = rem - |b|; if trial >= 0, rem = trial and quo[0]=1.
  - After WIDTH iterations -> FIX.
- FIX (one cycle):
  - quotient negated if sign(a) != sign(b).
  - remainder negated if a is negative.
  - Result is truncation toward zero; remainder takes the dividend's sign.
  - Then -> DONE.
- DONE (one cycle): done=1; hi/lo written (not written on div-by-zero). Then -> IDLE.
- Divide by zero: DONE is entered the cycle after start; div_zero=1; hi/lo keep their previous values.
- div_zero holds until the next accepted start.
- Latency, counted from the accepting edge to the cycle in which done is high:
  - MULT: WIDTH+1 cycles.
  - DIV: WIDTH+2 cycles.
  - DIV by 0: 1 cycle.
- busy=1 in MULT/DIV/FIX/DONE.
- start while not in IDLE is ignored; there is no queuing.
- Overflow: -2^(W-1) / -1 gives lo=0x80000000, hi=0, with no flag. MULT never overflows because the full 2W-bit product is kept.
- hi/lo are stable between completions; operand changes after acceptance have no effect.
- reset mid-operation: immediately returns to IDLE; no done pulse; hi/lo cleared.
- The iteration counter is $clog2(WIDTH)+1 bits and counts 0..WIDTH-1.

Decomposition:
- Package mult_div_pkg holds:
  - state_t enum (IDLE, MULT, DIV, FIX, DONE)
  - OP_MULT=1'b0, OP_DIV=1'b1
  - default WIDTH constant
- No sub-module. Booth step and restoring step are each a few lines of combinational logic inside the FSM block; the abs/negate helpers are package functions.

Test Plan:
- MULT 7 x -3 (0xFFFFFFFD) -> done exactly 33 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000. MULT 0x80000000 x 1 -> hi=0xFFFFFFFF, lo=0x80000000.
- DIV -7 / 2 -> done 34 cycles after start; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 7 / -2 -> lo=0xFFFFFFFD, hi=0x00000001.
- DIV 5 / 0 with prior hi=lo=0x12345678 -> done and div_zero the next cycle; hi/lo remain 0x12345678; div_zero clears on the next start.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. DIV 0 / 9 -> lo=0, hi=0.
- Control cases:
  - Start a MULT; pulse start with op=DIV at cycle 10 -> ignored, MULT result correct.
  - Assert reset at cycle 15 of a MULT -> no done; hi=lo=0; busy=0; a new start is accepted the cycle after reset deasserts.

Source files
------------

// File: rtl/mult_div_pkg.sv
// Shared types and helpers for the sequential multiply/divide unit.
package mult_div_pkg;

    // Operand/result width the unit is normally built at; the magnitude
    // helpers below are sized to it.
    localparam int DEFAULT_WIDTH = 32;

    // Operation select encoding on the op input.
    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        DIV,
        FIX,
        DONE
    } state_t;

    // Two's complement negation.
    function automatic logic [DEFAULT_WIDTH-1:0] negate(input logic [DEFAULT_WIDTH-1:0] x);
        return ~x + 1'b1;
    endfunction

    // Unsigned magnitude of a signed value; the most negative value maps
    // to 2^(W-1), which is representable as an unsigned W-bit number.
    function automatic logic [DEFAULT_WIDTH-1:0] abs_val(input logic [DEFAULT_WIDTH-1:0] x);
        return x[DEFAULT_WIDTH-1] ? negate(x) : x;
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Sequential signed multiply (radix-2 Booth) / divide (restoring on
// magnitudes with sign fix-up) unit producing HI/LO results.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t r_state;
    state_t w_next;

    // Booth multiplier state: acc carries one extra bit so that
    // subtracting -2^(W-1) cannot wrap.
    logic [WIDTH:0]   r_acc;
    logic [WIDTH-1:0] r_q;
    logic             r_q1;
    logic [WIDTH:0]   r_m;

    // Restoring divider state on unsigned magnitudes.
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_b_abs;
    logic             r_neg_q;
    logic             r_neg_r;

    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;
    logic             r_div_zero;

    logic [WIDTH:0]   w_booth_sum;
    logic [WIDTH:0]   w_acc_nx;
    logic [WIDTH-1:0] w_q_nx;
    logic [WIDTH+1:0] w_trial;
    logic [WIDTH:0]   w_rem_nx;
    logic [WIDTH-1:0] w_quo_nx;
    logic [WIDTH-1:0] w_rem_fix;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_a_abs;
    logic [WIDTH-1:0] w_b_abs;
    logic             w_last;

    assign w_a_abs = abs_val(a_in);
    assign w_b_abs = abs_val(b_in);
    assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));

    // Booth step: add/subtract m according to the recoded bit pair.
    always_comb begin
        w_booth_sum = r_acc;
        case ({r_q[0], r_q1})
            2'b01:   w_booth_sum = r_acc + r_m;
            2'b10:   w_booth_sum = r_acc - r_m;
            default: w_booth_sum = r_acc;
        endcase
    end

    // Arithmetic right shift of {acc, q, q_1}; q_1 takes the old q[0].
    assign w_acc_nx = {w_booth_sum[WIDTH], w_booth_sum[WIDTH:1]};
    assign w_q_nx   = {w_booth_sum[0], r_q[WIDTH-1:1]};

    // Restoring step: shift {rem, quo} left, keep the trial difference
    // when it does not go negative.
    assign w_trial  = {r_rem, r_quo[WIDTH-1]} - {2'b00, r_b_abs};
    assign w_quo_nx = {r_quo[WIDTH-2:0], ~w_trial[WIDTH+1]};
    assign w_rem_nx = w_trial[WIDTH+1] ? {r_rem[WIDTH-1:0], r_quo[WIDTH-1]}
                                       : w_trial[WIDTH:0];

    // Sign fix-up: truncation toward zero, remainder follows the dividend.
    assign w_quo_fix = r_neg_q ? negate(r_quo) : r_quo;
    assign w_rem_fix = r_neg_r ? negate(r_rem[WIDTH-1:0]) : r_rem[WIDTH-1:0];

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a start outside IDLE is simply not looked at.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (op == OP_MULT) begin
                        w_next = MULT;
                    end else if (b_in == '0) begin
                        w_next = DONE;
                    end else begin
                        w_next = DIV;
                    end
                end
            end
            MULT:    if (w_last) w_next = DONE;
            DIV:     if (w_last) w_next = FIX;
            FIX:     w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, and result write into HI/LO
    // on the edge that enters DONE so they are valid alongside done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc      <= '0;
            r_q        <= '0;
            r_q1       <= 1'b0;
            r_m        <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_b_abs    <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_cnt      <= '0;
                        r_div_zero <= 1'b0;
                        r_acc      <= '0;
                        r_q        <= a_in;
                        r_q1       <= 1'b0;
                        r_m        <= {b_in[WIDTH-1], b_in};
                        r_rem      <= '0;
                        r_quo      <= w_a_abs;
                        r_b_abs    <= w_b_abs;
                        r_neg_q    <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
                        r_neg_r    <= a_in[WIDTH-1];
                        if (op == OP_DIV && b_in == '0) begin
                            r_div_zero <= 1'b1;
                            r_done     <= 1'b1;
                        end
                    end
                end
                MULT: begin
                    r_acc <= w_acc_nx;
                    r_q   <= w_q_nx;
                    r_q1  <= r_q[0];
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_hi   <= w_acc_nx[WIDTH-1:0];
                        r_lo   <= w_q_nx;
                        r_done <= 1'b1;
                    end
                end
                DIV: begin
                    r_rem <= w_rem_nx;
                    r_quo <= w_quo_nx;
                    r_cnt <= r_cnt + 1'b1;
                end
                FIX: begin
                    r_hi   <= w_rem_fix;
                    r_lo   <= w_quo_fix;
                    r_done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy     = (r_state != IDLE);
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit with an expected-result queue.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         op;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           lat;
    } exp_t;

    exp_t scb[$];
    int   tests = 0;
    int   fails = 0;
    logic [W-1:0] model_hi = '0;
    logic [W-1:0] model_lo = '0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a_in     (a_in),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    // Reference model from native 64-bit signed arithmetic.
    function automatic exp_t model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        logic [63:0] p;
        logic [63:0] qq;
        logic [63:0] rr;
        if (!o) begin
            p = sa * sb;
            e.hi = p[63:32]; e.lo = p[31:0]; e.dz = 1'b0; e.lat = 33;
        end else if (b == '0) begin
            e.hi = model_hi; e.lo = model_lo; e.dz = 1'b1; e.lat = 1;
        end else begin
            qq = sa / sb;
            rr = sa % sb;
            e.hi = rr[31:0]; e.lo = qq[31:0]; e.dz = 1'b0; e.lat = 34;
        end
        return e;
    endfunction

    task automatic push_exp(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e = model(o, a, b);
        scb.push_back(e);
        if (!(o && b == '0)) begin
            model_hi = e.hi;
            model_lo = e.lo;
        end
    endtask

    // Issue one operation and wait (bounded) for done; operands are
    // scrambled right after acceptance.
    task automatic run_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] oh, output logic [W-1:0] ol,
                          output logic odz, output logic odz0, output int lat, output bit ok);
        push_exp(o, a, b);
        @(posedge clk); #1;
        start = 1'b1; op = o; a_in = a; b_in = b;
        @(posedge clk); #1;
        start = 1'b0; op = 1'($urandom); a_in = $urandom; b_in = $urandom;
        odz0 = div_zero;
        lat = 1;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        ok = done; oh = hi; ol = lo; odz = div_zero;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; op = 1'b0; a_in = '0; b_in = '0;
        #12;
        tests++;
        if ({busy, done, div_zero} !== 3'b000) begin
            fails++; $display("FAIL reset_ctrl busy/done/dz got %b want 000", {busy, done, div_zero});
        end
        tests++;
        if ({hi, lo} !== 64'h0) begin
            fails++; $display("FAIL reset_hilo got %h_%h want 0", hi, lo);
        end
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_mult();
        logic [W-1:0] ta[4] = '{32'h00000007, 32'h80000000, 32'h80000000, 32'h7FFFFFFF};
        logic [W-1:0] tb[4] = '{32'hFFFFFFFD, 32'h80000000, 32'h00000001, 32'h7FFFFFFF};
        logic [W-1:0] oh, ol; logic odz, odz0; int lat; bit ok; exp_t e;
        for (int i = 0; i < 4; i++) begin
            run_op(1'b0, ta[i], tb[i], oh, ol, odz, odz0, lat, ok);
            e = scb.pop_front();
            tests++;
            if (!ok) begin
                fails++; $display("FAIL mult_timeout a=%h b=%h no done within %0d cycles", ta[i], tb[i], lat);
            end else begin
                if ({oh, ol, odz} !== {e.hi, e.lo, e.dz}) begin
                    fails++; $display("FAIL mult_result a=%h b=%h got %h_%h dz=%b want %h_%h dz=%b",
                                      ta[i], tb[i], oh, ol, odz, e.hi, e.lo, e.dz);
                end
                tests++;
                if (lat != e.lat) begin
                    fails++; $display("FAIL mult_latency a=%h b=%h got %0d want %0d", ta[i], tb[i], lat, e.lat);
                end
            end
        end
    endtask

    task automatic test_div();
        logic [W-1:0] ta[5] = '{32'hFFFFFFF9, 32'h00000007, 32'h80000000, 32'h00000000, 32'hFFFFFF9C};
        logic [W-1:0] tb[5] = '{32'h00000002, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000009, 32'hFFFFFFF9};
        logic [W-1:0] oh, ol; logic odz, odz0; int lat; bit ok; exp_t e;
        for (int i = 0; i < 5; i++) begin
            run_op(1'b1, ta[i], tb[i], oh, ol, odz, odz0, lat, ok);
            e = scb.pop_front();
            tests++;
            if (!ok) begin
                fails++; $display("FAIL div_timeout a=%h b=%h no done within %0d cycles", ta[i], tb[i], lat);
            end else begin
                if ({oh, ol, odz} !== {e.hi, e.lo, e.dz}) begin
                    fails++; $display("FAIL div_result a=%h b=%h got hi=%h lo=%h dz=%b want hi=%h lo=%h dz=%b",
                                      ta[i], tb[i], oh, ol, odz, e.hi, e.lo, e.dz);
                end
                tests++;
                if (lat != e.lat) begin
                    fails++; $display("FAIL div_latency a=%h b=%h got %0d want %0d", ta[i], tb[i], lat, e.lat);
                end
            end
        end
    endtask

    task automatic test_div_zero();
        logic [W-1:0] oh, ol; logic odz, odz0; int lat; bit ok; exp_t e;
        // Prime HI/LO with known non-zero values.
        run_op(1'b0, 32'h12345678, 32'h00000010, oh, ol, odz, odz0, lat, ok);
        e = scb.pop_front();
        tests++;
        if (!ok || {oh, ol} !== {e.hi, e.lo}) begin
            fails++; $display("FAIL dz_prime got %h_%h want %h_%h", oh, ol, e.hi, e.lo);
        end
        run_op(1'b1, 32'h00000005, 32'h00000000, oh, ol, odz, odz0, lat, ok);
        e = scb.pop_front();
        tests++;
        if (!ok || lat != e.lat) begin
            fails++; $display("FAIL dz_latency got %0d want %0d", lat, e.lat);
        end
        tests++;
        if ({oh, ol, odz} !== {e.hi, e.lo, e.dz}) begin
            fails++; $display("FAIL dz_result got hi=%h lo=%h dz=%b want hi=%h lo=%h dz=%b",
                              oh, ol, odz, e.hi, e.lo, e.dz);
        end
        @(posedge clk); #1;
        tests++;
        if (div_zero !== 1'b1) begin
            fails++; $display("FAIL dz_hold got %b want 1", div_zero);
        end
        run_op(1'b0, 32'h00000003, 32'h00000004, oh, ol, odz, odz0, lat, ok);
        e = scb.pop_front();
        tests++;
        if (odz0 !== 1'b0) begin
            fails++; $display("FAIL dz_clear_on_start got %b want 0", odz0);
        end
        tests++;
        if (!ok || {oh, ol, odz} !== {e.hi, e.lo, e.dz}) begin
            fails++; $display("FAIL dz_next_result got %h_%h want %h_%h", oh, ol, e.hi, e.lo);
        end
    endtask

    task automatic test_start_ignored();
        int lat; exp_t e;
        push_exp(1'b0, 32'h00001234, 32'hFFFF0001);
        @(posedge clk); #1;
        start = 1'b1; op = 1'b0; a_in = 32'h00001234; b_in = 32'hFFFF0001;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            if (lat == 10) begin
                start = 1'b1; op = 1'b1; a_in = 32'd100; b_in = 32'd7;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        e = scb.pop_front();
        tests++;
        if (!done || lat != e.lat) begin
            fails++; $display("FAIL ignore_latency got %0d want %0d", lat, e.lat);
        end
        tests++;
        if ({hi, lo, div_zero} !== {e.hi, e.lo, e.dz}) begin
            fails++; $display("FAIL ignore_result got %h_%h want %h_%h", hi, lo, e.hi, e.lo);
        end
    endtask

    task automatic test_reset_mid();
        int lat; exp_t e;
        @(posedge clk); #1;
        start = 1'b1; op = 1'b0; a_in = 32'd5; b_in = 32'd6;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i < 15; i++) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
        #2;
        tests++;
        if ({busy, done} !== 2'b00) begin
            fails++; $display("FAIL midreset_ctrl busy/done got %b want 00", {busy, done});
        end
        tests++;
        if ({hi, lo} !== 64'h0) begin
            fails++; $display("FAIL midreset_hilo got %h_%h want 0", hi, lo);
        end
        model_hi = '0; model_lo = '0;
        @(posedge clk); #1;
        tests++;
        if (done !== 1'b0) begin
            fails++; $display("FAIL midreset_done got %b want 0", done);
        end
        push_exp(1'b1, 32'd100, 32'd7);
        reset = 1'b1;
        start = 1'b1; op = 1'b1; a_in = 32'd100; b_in = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        tests++;
        if (busy !== 1'b1) begin
            fails++; $display("FAIL midreset_restart busy got %b want 1", busy);
        end
        lat = 1;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        e = scb.pop_front();
        tests++;
        if (!done || lat != e.lat || {hi, lo} !== {e.hi, e.lo}) begin
            fails++; $display("FAIL midreset_result got hi=%h lo=%h lat=%0d want hi=%h lo=%h lat=%0d",
                              hi, lo, lat, e.hi, e.lo, e.lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] oh, ol, a, b; logic o, odz, odz0; int lat; bit ok; exp_t e;
        for (int i = 0; i < 16; i++) begin
            o = 1'($urandom);
            a = (i % 5 == 0) ? 32'h80000000 : $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom >> $urandom_range(0, 28);
            if ($urandom_range(0, 1) == 1) b = -b;
            run_op(o, a, b, oh, ol, odz, odz0, lat, ok);
            e = scb.pop_front();
            tests++;
            if (!ok || lat != e.lat) begin
                fails++; $display("FAIL b2b_latency op=%b a=%h b=%h got %0d want %0d", o, a, b, lat, e.lat);
            end
            tests++;
            if ({oh, ol, odz} !== {e.hi, e.lo, e.dz}) begin
                fails++; $display("FAIL b2b_result op=%b a=%h b=%h got hi=%h lo=%h dz=%b want hi=%h lo=%h dz=%b",
                                  o, a, b, oh, ol, odz, e.hi, e.lo, e.dz);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
